// File: rtl/dogx_pcm_pkg.sv
// Shared types for the PCM frame transmitter.
// Frame layout, FSM states and parity helper.
package dogx_pcm_pkg;

    localparam int TX_SEQ_W = 4;
    localparam int SUM_W    = 11;
    localparam int FRAME_W  = TX_SEQ_W + SUM_W + 1;

    typedef struct packed {
        logic [TX_SEQ_W-1:0] seq;
        logic [SUM_W-1:0]    sum;
        logic                parity;
    } frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    function automatic logic even_par(input logic [FRAME_W-2:0] i_v);
        return ^i_v;
    endfunction

    function automatic frame_t pack_frame(
        input logic [TX_SEQ_W-1:0] i_seq,
        input logic [SUM_W-1:0]    i_sum
    );
        frame_t f;
        f.seq    = i_seq;
        f.sum    = i_sum;
        f.parity = even_par({i_seq, i_sum});
        return f;
    endfunction

endpackage

// File: rtl/pcm_word_fifo2.sv
// Two-entry word buffer between the decimator and the serialiser.
// A push on a full buffer is refused unless a pop frees a slot in the same cycle.
module pcm_word_fifo2 #(
    parameter int W = 11
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    logic [W-1:0] r_mem [2];
    logic         r_wr;
    logic         r_rd;
    logic [1:0]   r_cnt;
    logic         w_rd_ok;
    logic         w_wr_ok;

    assign w_rd_ok = i_pop & (r_cnt != 2'd0);
    assign w_wr_ok = i_push & ((r_cnt != 2'd2) | w_rd_ok);
    assign o_data  = r_mem[r_rd];
    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);

    // Storage, pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_wr_ok) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (w_rd_ok) begin
                r_rd <= ~r_rd;
            end
            unique case ({w_wr_ok, w_rd_ok})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/pcm_frame_tx.sv
// Decimate-by-4 summing of audio samples and 16-bit serial framing.
// sdo/fs change only on the edge where sclk falls.
module pcm_frame_tx
    import dogx_pcm_pkg::*;
#(
    parameter int DATA_W     = 9,
    parameter int DECIM_LOG2 = 2,
    parameter int SEQ_W      = 4
) (
    input  logic              CLK_24M,
    input  logic              reset,
    input  logic              enable_3M,
    input  logic [DATA_W-1:0] s_data,
    input  logic              tx_en,
    output logic              sclk,
    output logic              fs,
    output logic              sdo,
    output logic              overflow
);

    logic [SUM_W-1:0]      r_acc;
    logic [SUM_W-1:0]      r_word;
    logic [DECIM_LOG2-1:0] r_phase;
    logic                  r_push;
    logic                  r_sclk;
    tx_state_t             r_state;
    logic [3:0]            r_bit;
    logic [FRAME_W-1:0]    r_shift;
    logic [SEQ_W-1:0]      r_seq;
    logic                  r_fs;
    logic                  r_sdo;
    logic                  r_ovf;

    logic [SUM_W-1:0]      w_samp;
    logic [SUM_W-1:0]      w_sum;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [SUM_W-1:0]      w_head;
    logic                  w_frame_end;
    logic [SEQ_W-1:0]      w_seq_ld;
    frame_t                w_frame;
    logic [FRAME_W-1:0]    w_frame_v;

    assign w_samp      = {{(SUM_W-DATA_W){s_data[DATA_W-1]}}, s_data};
    assign w_sum       = r_acc + w_samp;
    assign w_push      = r_push & tx_en;
    assign w_frame_end = (r_state == SHIFT) && (r_bit == 4'd0);
    assign w_pop       = r_sclk & tx_en & ~w_empty
                       & ((r_state == IDLE) | w_frame_end);
    assign w_seq_ld    = (r_state == SHIFT) ? r_seq + SEQ_W'(1) : r_seq;
    assign w_frame     = pack_frame(w_seq_ld, w_head);
    assign w_frame_v   = w_frame;

    assign sclk     = r_sclk;
    assign fs       = r_fs;
    assign sdo      = r_sdo;
    assign overflow = r_ovf;

    pcm_word_fifo2 #(
        .W (SUM_W)
    ) u_fifo (
        .i_clk   (CLK_24M),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_word),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sum four samples; the finished word is offered to the buffer next cycle
    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            r_acc   <= '0;
            r_word  <= '0;
            r_phase <= '0;
            r_push  <= 1'b0;
        end else begin
            r_push <= enable_3M & (&r_phase);
            if (enable_3M) begin
                r_phase <= r_phase + DECIM_LOG2'(1);
                if (&r_phase) begin
                    r_word <= w_sum;
                    r_acc  <= '0;
                end else begin
                    r_acc  <= w_sum;
                end
            end
        end
    end

    // Free-running bit clock at half the system rate
    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            r_sclk <= 1'b0;
        end else begin
            r_sclk <= ~r_sclk;
        end
    end

    // Sticky flag for a word refused by a full buffer
    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | (w_push & w_full & ~w_pop);
        end
    end

    // Serialiser: load, shift MSB first, chain frames without a gap
    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_bit   <= 4'd0;
            r_shift <= '0;
            r_seq   <= '0;
            r_fs    <= 1'b0;
            r_sdo   <= 1'b0;
        end else if (r_sclk) begin
            unique case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_frame_v;
                        r_sdo   <= w_frame_v[FRAME_W-1];
                        r_fs    <= 1'b1;
                        r_bit   <= 4'd15;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_bit != 4'd0) begin
                        r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                        r_sdo   <= r_shift[FRAME_W-2];
                        r_fs    <= 1'b0;
                        r_bit   <= r_bit - 4'd1;
                    end else begin
                        r_seq <= r_seq + SEQ_W'(1);
                        if (w_pop) begin
                            r_shift <= w_frame_v;
                            r_sdo   <= w_frame_v[FRAME_W-1];
                            r_fs    <= 1'b1;
                            r_bit   <= 4'd15;
                        end else begin
                            r_sdo   <= 1'b0;
                            r_fs    <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_frame_tx.sv
// Scoreboard bench for pcm_frame_tx.
// A queue-level link model predicts frames; a serial monitor decodes and compares.
module tb_pcm_frame_tx;

    logic       CLK_24M   = 1'b0;
    logic       reset     = 1'b0;
    logic       enable_3M = 1'b0;
    logic [8:0] s_data    = 9'd0;
    logic       tx_en     = 1'b0;
    logic       sclk;
    logic       fs;
    logic       sdo;
    logic       overflow;

    int n_vec = 0;
    int n_bad = 0;

    always #21 CLK_24M = ~CLK_24M;

    pcm_frame_tx dut (
        .CLK_24M   (CLK_24M),
        .reset     (reset),
        .enable_3M (enable_3M),
        .s_data    (s_data),
        .tx_en     (tx_en),
        .sclk      (sclk),
        .fs        (fs),
        .sdo       (sdo),
        .overflow  (overflow)
    );

    function automatic logic [15:0] pack(input int seq, input int sum);
        logic [15:0] f;
        f[15:12] = 4'(seq);
        f[11:1]  = 11'(sum);
        f[0]     = ^f[15:1];
        return f;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Words are sums of four samples, buffered two deep; the link takes a
    // word when free and sclk is high, and is then busy for 32 cycles.
    int          m_samp[$];
    int          m_buf[$];
    logic [15:0] mq[$];
    int          m_pend;
    bit          m_pend_v;
    bit          m_sclk;
    longint      m_cyc;
    longint      m_free;
    int          m_seq;
    bit          m_ovf;

    initial forever begin
        @(posedge CLK_24M or negedge reset);
        if (!reset) begin
            m_samp.delete();
            m_buf.delete();
            mq.delete();
            m_pend_v = 0;
            m_sclk   = 0;
            m_cyc    = 0;
            m_free   = 0;
            m_seq    = 0;
            m_ovf    = 0;
        end else begin
            if (m_cyc >= m_free && m_sclk && tx_en && m_buf.size() > 0) begin
                mq.push_back(pack(m_seq, m_buf.pop_front()));
                m_seq  = (m_seq + 1) % 16;
                m_free = m_cyc + 32;
            end
            if (m_pend_v && tx_en) begin
                if (m_buf.size() < 2) m_buf.push_back(m_pend);
                else m_ovf = 1;
            end
            m_pend_v = 0;
            if (enable_3M) begin
                m_samp.push_back(int'($signed(s_data)));
                if (m_samp.size() == 4) begin
                    m_pend = 0;
                    foreach (m_samp[i]) m_pend += m_samp[i];
                    m_pend_v = 1;
                    m_samp.delete();
                end
            end
            m_sclk = ~m_sclk;
            m_cyc++;
        end
    end

    // ---------------- serial monitor ----------------
    bit          rx_busy = 0;
    int          rx_cnt  = 0;
    logic [15:0] rx_sh;
    logic [15:0] rx_log[$];
    int          fs_log[$];
    int          mcyc    = 0;

    initial forever begin
        @(negedge CLK_24M);
        mcyc++;
        if (!reset) begin
            rx_busy = 0;
            rx_cnt  = 0;
        end else if (sclk) begin
            if (fs) begin
                if (rx_busy) chk("fs_mid_frame", rx_cnt, 16);
                rx_sh   = {15'd0, sdo};
                rx_cnt  = 1;
                rx_busy = 1;
                fs_log.push_back(mcyc);
            end else if (rx_busy) begin
                rx_sh = {rx_sh[14:0], sdo};
                rx_cnt++;
                if (rx_cnt == 16) begin
                    rx_busy = 0;
                    rx_log.push_back(rx_sh);
                    chk("parity", int'(^rx_sh[15:1]), int'(rx_sh[0]));
                    if (mq.size() == 0) begin
                        chk("unexpected_frame", int'(rx_sh), -1);
                    end else begin
                        chk("frame", int'(rx_sh), int'(mq.pop_front()));
                    end
                end
            end else begin
                chk("idle_sdo", int'(sdo), 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [8:0] v, input int gap);
        enable_3M = 1'b1;
        s_data    = v;
        @(negedge CLK_24M);
        enable_3M = 1'b0;
        repeat (gap - 1) @(negedge CLK_24M);
    endtask

    task automatic do_reset();
        @(negedge CLK_24M);
        reset     = 1'b0;
        tx_en     = 1'b0;
        enable_3M = 1'b0;
        repeat (2) @(negedge CLK_24M);
        rx_log.delete();
        fs_log.delete();
        reset = 1'b1;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while ((mq.size() != 0 || rx_busy || m_buf.size() != 0 || m_pend_v)
               && t < 4000) begin
            @(negedge CLK_24M);
            t++;
        end
        chk(nm, int'(t < 4000), 1);
        repeat (8) @(negedge CLK_24M);
    endtask

    task automatic wait_bits(input string nm, input int n);
        int t = 0;
        while (!(rx_busy && rx_cnt >= n) && t < 300) begin
            @(negedge CLK_24M);
            t++;
        end
        chk(nm, int'(t < 300), 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        int sum;
        logic [8:0] v;

        repeat (3) @(negedge CLK_24M);
        chk("rst_sclk", int'(sclk), 0);
        chk("rst_fs", int'(fs), 0);
        chk("rst_sdo", int'(sdo), 0);
        chk("rst_ovf", int'(overflow), 0);
        reset = 1'b1;

        // four samples of +10, latency to frame sync
        do_reset();
        tx_en = 1'b1;
        repeat (3) send(9'd10, 8);
        send(9'd10, 1);
        lat = 0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge CLK_24M);
            if (fs) lat = k;
        end
        chk("fs_latency_ok", int'(lat == 2 || lat == 3), 1);
        drain("drain_t1");
        chk("t1_count", rx_log.size(), 1);
        chk("t1_frame", int'(rx_log[0]), 16'h0050);

        // -1 x4 then +255 x4, back-to-back frames
        do_reset();
        tx_en = 1'b1;
        repeat (4) send(9'h1FF, 8);
        repeat (4) send(9'd255, 8);
        drain("drain_t2");
        chk("t2_count", rx_log.size(), 2);
        chk("t2_frame0", int'(rx_log[0]), 16'h0FF9);
        chk("t2_frame1", int'(rx_log[1]), int'(pack(1, 1020)));
        chk("t2_gap", fs_log[1] - fs_log[0], 32);

        // most negative sum
        do_reset();
        tx_en = 1'b1;
        repeat (4) send(9'h100, 8);
        drain("drain_t3");
        chk("t3_frame", int'(rx_log[0]), 16'h0801);

        // 17 frames of random samples at nominal rate
        do_reset();
        tx_en = 1'b1;
        repeat (68) send(9'($urandom_range(0, 511)), 8);
        drain("drain_t4");
        chk("t4_count", rx_log.size(), 17);
        for (int i = 0; i < 17; i++) begin
            chk("t4_seq", int'(rx_log[i][15:12]), i % 16);
            if (i > 0) chk("t4_gap", fs_log[i] - fs_log[i-1], 32);
        end
        chk("t4_ovf", int'(overflow), 0);

        // double-rate enables overrun the buffer
        do_reset();
        tx_en = 1'b1;
        repeat (32) send(9'($urandom_range(0, 511)), 4);
        drain("drain_t5");
        chk("t5_ovf_set", int'(overflow), 1);
        chk("t5_ovf_model", int'(overflow), int'(m_ovf));
        repeat (100) @(negedge CLK_24M);
        chk("t5_ovf_sticky", int'(overflow), 1);

        // reset in the middle of a frame, with a partial accumulation
        repeat (3) send(9'($urandom_range(0, 511)), 8);
        send(9'($urandom_range(0, 511)), 1);
        repeat (2) send(9'($urandom_range(0, 511)), 2);
        wait_bits("t6_reach_bit7", 8);
        reset = 1'b0;
        #1;
        chk("t6_sclk", int'(sclk), 0);
        chk("t6_sdo", int'(sdo), 0);
        chk("t6_fs", int'(fs), 0);
        chk("t6_ovf", int'(overflow), 0);
        rx_log.delete();
        fs_log.delete();
        repeat (2) @(negedge CLK_24M);
        reset = 1'b1;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            v = 9'($urandom_range(0, 511));
            sum += int'($signed(v));
            send(v, 8);
        end
        drain("drain_t6");
        chk("t6_count", rx_log.size(), 1);
        chk("t6_frame", int'(rx_log[0]), int'(pack(0, sum)));

        // tx_en drops mid-frame
        do_reset();
        tx_en = 1'b1;
        repeat (4) send(9'($urandom_range(0, 511)), 8);
        wait_bits("t7_reach_bit", 6);
        tx_en = 1'b0;
        repeat (4) send(9'($urandom_range(0, 511)), 8);
        drain("drain_t7");
        repeat (64) @(negedge CLK_24M);
        chk("t7_count", rx_log.size(), 1);
        chk("t7_sdo_idle", int'(sdo), 0);
        chk("t7_fs_idle", int'(fs), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
